bobing_dice_roller: RTL

- Produces one six-dice BoBing throw for the scoring block.
- Uses a free-running 16-bit Galois LFSR and rejection sampling, so every die value is in the range 1..6.
- On a roll request, fills D1..D6 in order, one accepted die per cycle.
- Then presents the throw with valid held high until the next roll or reseed.
- Sits between game control (roll/seed) and the scorer's D1..D6 inputs.

---
 rtl/bobing_dice_roller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bobing_dice_roller.sv
`default_nettype none
// ============================================================================
// Module   : bobing_dice_roller
// Purpose  : Produces one six-dice BoBing throw for the scoring block.
//            A free-running 16-bit right-shift Galois LFSR supplies draws.
//            Each draw's low three bits are a die candidate. Candidates 0 and
//            7 are rejected and the draw is retried. A bounded fallback draw
//            guarantees forward progress. The dice are filled D1..D6 in
//            order, one accepted die per cycle. The throw is then held with
//            valid high until the next roll or reseed.
// Ports    : clk          - rising-edge clock
//            rst          - asynchronous, active-high reset
//            roll_i       - start a throw (ignored while a throw is running)
//            seed_load_i  - load seed_in_i into the LFSR, abort any throw
//            seed_in_i    - new LFSR seed (zero is replaced by SEED)
//            busy_o       - high while the throw is being generated
//            valid_o      - high while d1_o..d6_o hold a complete throw
//            d1_o..d6_o   - registered die values (0 only before first write)
// Params   : SEED         - LFSR reset value, also used for a zero seed
//            MAX_TRIES    - consecutive rejects that force a fallback draw,
//                           legal range 1..15
// Revision : 1.0 - initial release
// ============================================================================
module bobing_dice_roller #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        roll_i,
  input  logic        seed_load_i,
  input  logic [15:0] seed_in_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [2:0]  d1_o,
  output logic [2:0]  d2_o,
  output logic [2:0]  d3_o,
  output logic [2:0]  d4_o,
  output logic [2:0]  d5_o,
  output logic [2:0]  d6_o
);

  // Feedback mask of the right-shift Galois LFSR (maximal length, 16 bits).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Reject-counter value at which the next rejected draw becomes a fallback.
  localparam logic [3:0]  RC_LAST   = 4'(MAX_TRIES - 1);

  localparam logic [2:0]  K_FIRST   = 3'd1;
  localparam logic [2:0]  K_LAST    = 3'd6;
  localparam int          N_DICE    = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROLL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [2:0]  k_q;               // index (1..6) of the die being filled
  logic [3:0]  rc_q;              // consecutive rejected draws for die k
  logic [2:0]  die_q [N_DICE];    // die_q[0] is D1
  logic        busy_q;
  logic        valid_q;

  // --------------------------------------------------------------------------
  // Next-state helpers
  // --------------------------------------------------------------------------
  logic [15:0] lfsr_step_d;       // LFSR value after one free-running step
  logic [15:0] lfsr_seed_d;       // LFSR value on a seed-load edge
  logic [2:0]  cand_d;            // die candidate from the current LFSR value
  logic        cand_ok_d;         // candidate already in 1..6
  logic        fallback_d;        // this reject exhausts the retry budget
  logic        die_write_d;       // a die is committed on this ROLL edge
  logic [2:0]  die_val_d;         // value committed when die_write_d is set

  always_comb begin
    lfsr_step_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // A zero seed would lock the LFSR at zero forever.
    lfsr_seed_d = (seed_in_i == 16'h0000) ? SEED : seed_in_i;

    cand_d      = lfsr_q[2:0];
    cand_ok_d   = (cand_d != 3'd0) && (cand_d != 3'd7);
    fallback_d  = !cand_ok_d && (rc_q == RC_LAST);
    die_write_d = cand_ok_d || fallback_d;

    // The fallback maps the two low bits onto 1..4. That range is slightly
    // biased, but it bounds the latency of a throw.
    if (cand_ok_d) begin
      die_val_d = cand_d;
    end else begin
      die_val_d = {1'b0, lfsr_q[1:0]} + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Controller, LFSR and die registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      k_q     <= K_FIRST;
      rc_q    <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < N_DICE; i++) begin
        die_q[i] <= 3'd0;
      end
    end else if (seed_load_i) begin
      // Reseed wins over roll. The dice are deliberately left untouched.
      lfsr_q  <= lfsr_seed_d;
      state_q <= S_IDLE;
      k_q     <= K_FIRST;
      rc_q    <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // The LFSR free-runs on every non-seed edge, in every state.
      lfsr_q <= lfsr_step_d;

      case (state_q)
        S_IDLE: begin
          if (roll_i) begin
            state_q <= S_ROLL;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            k_q     <= K_FIRST;
            rc_q    <= 4'd0;
          end
        end

        S_ROLL: begin
          // roll_i is ignored here, so a held request cannot restart a throw.
          if (die_write_d) begin
            for (int i = 0; i < N_DICE; i++) begin
              if (k_q == 3'(i + 1)) begin
                die_q[i] <= die_val_d;
              end
            end
            rc_q <= 4'd0;
            if (k_q == K_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              k_q     <= K_FIRST;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end else begin
            rc_q <= rc_q + 4'd1;
          end
        end

        S_DONE: begin
          if (roll_i) begin
            state_q <= S_ROLL;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            k_q     <= K_FIRST;
            rc_q    <= 4'd0;
          end
        end

        default: begin
          // An unreachable encoding recovers to an idle, invalid controller.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          k_q     <= K_FIRST;
          rc_q    <= 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all directly from registers)
  // --------------------------------------------------------------------------
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign d1_o    = die_q[0];
  assign d2_o    = die_q[1];
  assign d3_o    = die_q[2];
  assign d4_o    = die_q[3];
  assign d5_o    = die_q[4];
  assign d6_o    = die_q[5];

endmodule

`default_nettype wire
